// File: rtl/tage_alloc_ctrl.sv
// TAGE tagged-table controller: provider/alt selection, update/allocate strobes, periodic u-clear sweep.
// Optional use_alt_on_na counter enabled by defining TAGE_USE_ALT_EN.
module tage_alloc_ctrl #(
  parameter int          NUM_TABLES    = 4,
  parameter int          IDX_WIDTH     = 10,
  parameter int          U_PERIOD_LOG2 = 18,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    pred_valid_i,
  output logic                    pred_ready_o,
  input  logic [NUM_TABLES-1:0]   tag_hit_i,
  input  logic [NUM_TABLES-1:0]   pred_i,
  input  logic [NUM_TABLES-1:0]   new_entry_i,
  input  logic [2*NUM_TABLES-1:0] u_i,
  input  logic                    base_pred_i,
  output logic                    pred_valid_o,
  output logic                    pred_o,
  input  logic                    res_valid_i,
  output logic                    res_ready_o,
  input  logic                    br_result_i,
  output logic [NUM_TABLES-1:0]   provider_o,
  output logic                    update_u_o,
  output logic [NUM_TABLES-1:0]   alloc_o,
  output logic [NUM_TABLES-1:0]   dec_u_o,
  output logic                    clr_valid_o,
  output logic [IDX_WIDTH-1:0]    clr_idx_o,
  output logic                    clr_col_o
);

  localparam int            PW  = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1;
  localparam logic [PW-1:0] TOP = PW'(NUM_TABLES - 1);

  typedef enum logic {RUN = 1'b0, SWEEP = 1'b1} state_t;

  typedef struct packed {
    logic                    hit;
    logic [PW-1:0]           prov;
    logic                    alt;
    logic                    final_pred;
    logic                    prov_pred;
    logic                    prov_new;
    logic [2*NUM_TABLES-1:0] u;
  } snap_t;

  state_t                   state_q, state_d;
  logic                     pending_q;
  snap_t                    snap_q, lk;
  logic [15:0]              lfsr_q;
  logic [U_PERIOD_LOG2-1:0] period_q;
  logic [IDX_WIDTH-1:0]     idx_q;
  logic                     col_q;
  logic                     pred_fire, res_fire, found1, found2, do_alloc;
  logic [NUM_TABLES-1:0]    cand, free_m, first_m, second_m, prov_nxt, alloc_nxt, dec_nxt;

`ifdef TAGE_USE_ALT_EN
  logic [3:0] use_alt_q;
`endif

  assign res_ready_o  = rst_ni && (state_q == RUN) && pending_q;
  assign res_fire     = res_valid_i && res_ready_o;
  assign pred_ready_o = rst_ni && (state_q == RUN) && (!pending_q || res_fire);
  assign pred_fire    = pred_valid_i && pred_ready_o;

  // Ascending scan: each new hit demotes the previous provider to alternate.
  always_comb begin
    lk     = '0;
    lk.alt = base_pred_i;
    for (int t = 0; t < NUM_TABLES; t++) begin
      if (tag_hit_i[t]) begin
        if (lk.hit) lk.alt = pred_i[lk.prov];
        lk.hit  = 1'b1;
        lk.prov = PW'(t);
      end
    end
    lk.prov_pred  = lk.hit ? pred_i[lk.prov] : base_pred_i;
    lk.prov_new   = lk.hit && new_entry_i[lk.prov];
    lk.final_pred = lk.prov_pred;
`ifdef TAGE_USE_ALT_EN
    if (lk.prov_new && use_alt_q[3]) lk.final_pred = lk.alt;
`endif
    lk.u = u_i;
  end

  // Allocation candidates are the longer-history tables above the provider.
  always_comb begin
    cand      = '0;
    free_m    = '0;
    first_m   = '0;
    second_m  = '0;
    prov_nxt  = '0;
    found1    = 1'b0;
    found2    = 1'b0;
    alloc_nxt = '0;
    dec_nxt   = '0;
    for (int j = 0; j < NUM_TABLES; j++) begin
      cand[j]     = !snap_q.hit || (PW'(j) > snap_q.prov);
      free_m[j]   = cand[j] && (snap_q.u[2*j +: 2] == 2'b00);
      prov_nxt[j] = snap_q.hit && (snap_q.prov == PW'(j));
      if (free_m[j]) begin
        if (!found1) begin
          first_m[j] = 1'b1;
          found1     = 1'b1;
        end else if (!found2) begin
          second_m[j] = 1'b1;
          found2      = 1'b1;
        end
      end
    end
    do_alloc = (br_result_i != snap_q.final_pred) && (!snap_q.hit || snap_q.prov != TOP);
    if (do_alloc) begin
      if (found1) alloc_nxt = (lfsr_q[0] && found2) ? second_m : first_m;
      else        dec_nxt   = cand;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pred_valid_o <= 1'b0;
      pred_o       <= 1'b0;
      provider_o   <= '0;
      update_u_o   <= 1'b0;
      alloc_o      <= '0;
      dec_u_o      <= '0;
      pending_q    <= 1'b0;
      snap_q       <= '0;
      lfsr_q       <= LFSR_SEED;
    end else begin
      pred_valid_o <= pred_fire;
      pred_o       <= pred_fire && lk.final_pred;
      provider_o   <= res_fire ? prov_nxt : '0;
      update_u_o   <= res_fire && snap_q.hit && (snap_q.prov_pred != snap_q.alt);
      alloc_o      <= res_fire ? alloc_nxt : '0;
      dec_u_o      <= res_fire ? dec_nxt : '0;
      if (pred_fire) begin
        pending_q <= 1'b1;
        snap_q    <= lk;
      end else if (res_fire) begin
        pending_q <= 1'b0;
      end
      if (res_fire) lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end
  end

`ifdef TAGE_USE_ALT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      use_alt_q <= 4'd8;
    end else if (res_fire && snap_q.prov_new && (snap_q.prov_pred != snap_q.alt)) begin
      if (br_result_i == snap_q.alt) begin
        if (use_alt_q != 4'hF) use_alt_q <= use_alt_q + 4'd1;
      end else if (use_alt_q != 4'h0) begin
        use_alt_q <= use_alt_q - 4'd1;
      end
    end
  end
`else
  logic unused_prov_new;
  assign unused_prov_new = snap_q.prov_new;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= RUN;
      period_q <= '0;
      idx_q    <= '0;
      col_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == RUN) begin
        period_q <= period_q + U_PERIOD_LOG2'(1);
      end else if (&idx_q) begin
        idx_q <= '0;
        col_q <= ~col_q;
      end else begin
        idx_q <= idx_q + IDX_WIDTH'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (&period_q) state_d = SWEEP;
      SWEEP:   if (&idx_q)    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  assign clr_valid_o = (state_q == SWEEP);
  assign clr_idx_o   = idx_q;
  assign clr_col_o   = col_q;

endmodule

// File: tb/tb_tage_alloc_ctrl.sv
// Scoreboard bench for tage_alloc_ctrl: drivers push expectations, a negedge monitor pops and compares.
module tb_tage_alloc_ctrl;
  localparam int          NT   = 4;
  localparam int          IW   = 3;
  localparam int          UP   = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0, rst_n = 1'b0;
  logic pred_valid_i = 0, res_valid_i = 0, br_result_i = 0, base_pred_i = 0;
  logic [NT-1:0] tag_hit_i = '0, pred_i = '0, new_entry_i = '0;
  logic [2*NT-1:0] u_i = '0;
  logic pred_ready_o, pred_valid_o, pred_o, res_ready_o, update_u_o, clr_valid_o, clr_col_o;
  logic [NT-1:0] provider_o, alloc_o, dec_u_o;
  logic [IW-1:0] clr_idx_o;

  always #5 clk = ~clk;

  tage_alloc_ctrl #(.NUM_TABLES(NT), .IDX_WIDTH(IW), .U_PERIOD_LOG2(UP), .LFSR_SEED(SEED)) dut (
    .clk_i(clk), .rst_ni(rst_n), .pred_valid_i(pred_valid_i), .pred_ready_o(pred_ready_o),
    .tag_hit_i(tag_hit_i), .pred_i(pred_i), .new_entry_i(new_entry_i), .u_i(u_i),
    .base_pred_i(base_pred_i), .pred_valid_o(pred_valid_o), .pred_o(pred_o),
    .res_valid_i(res_valid_i), .res_ready_o(res_ready_o), .br_result_i(br_result_i),
    .provider_o(provider_o), .update_u_o(update_u_o), .alloc_o(alloc_o), .dec_u_o(dec_u_o),
    .clr_valid_o(clr_valid_o), .clr_idx_o(clr_idx_o), .clr_col_o(clr_col_o));

  typedef struct packed {logic [3:0] prov; logic upd; logic [3:0] alloc; logic [3:0] dec;} res_t;
  typedef struct {
    logic [3:0] hit, pr, ne; logic [7:0] u; logic base, ep, br;
    logic [3:0] prov; logic upd; logic [3:0] a0, a1, dec;
  } vec_t;

  res_t  res_q[$];
  logic  pred_q[$];
  int    n_tests = 0, n_fail = 0;
  logic [15:0] lfsr_m = SEED;
  vec_t  vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timing model of the sweep schedule: 16 RUN cycles then 8 clear cycles.
  logic m_sweep = 0, m_col = 0;
  logic [UP-1:0] m_per = '0;
  logic [IW-1:0] m_idx = '0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sweep <= 0; m_per <= '0; m_idx <= '0; m_col <= 0;
    end else if (!m_sweep) begin
      m_per <= m_per + 1'b1;
      if (m_per == '1) m_sweep <= 1;
    end else if (m_idx == '1) begin
      m_sweep <= 0; m_idx <= '0; m_col <= ~m_col;
    end else begin
      m_idx <= m_idx + 1'b1;
    end
  end

  logic pf_prev = 0, rf_prev = 0, mon_e;
  res_t mon_r;
  always @(negedge clk) begin
    if (!rst_n) begin
      pf_prev = 0; rf_prev = 0;
    end else begin
      if (pf_prev) begin
        chk("pred_valid", pred_valid_o, 1);
        if (pred_q.size() != 0) begin
          mon_e = pred_q.pop_front();
          chk("pred_o", pred_o, mon_e);
        end else chk("pred_queue_empty", 1, 0);
      end else if (pred_valid_o) chk("pred_valid_spurious", pred_valid_o, 0);
      if (rf_prev) begin
        if (res_q.size() != 0) begin
          mon_r = res_q.pop_front();
          chk("res_strobes{prov,upd,alloc,dec}", {provider_o, update_u_o, alloc_o, dec_u_o}, mon_r);
        end else chk("res_queue_empty", 1, 0);
      end else if ({provider_o, update_u_o, alloc_o, dec_u_o} != '0)
        chk("res_strobes_spurious", {provider_o, update_u_o, alloc_o, dec_u_o}, 0);
      chk("clr{valid,idx,col}", {clr_valid_o, clr_idx_o, clr_col_o}, {m_sweep, m_idx, m_col});
      if (m_sweep) chk("ready_in_sweep", {pred_ready_o, res_ready_o}, 0);
      pf_prev = pred_valid_i && pred_ready_o;
      rf_prev = res_valid_i && res_ready_o;
    end
  end

  task automatic do_pred(input logic [3:0] hit, pr, ne, input logic [7:0] u, input logic base, ep);
    tag_hit_i = hit; pred_i = pr; new_entry_i = ne; u_i = u; base_pred_i = base; pred_valid_i = 1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (pred_ready_o) begin
        pred_q.push_back(ep);
        @(posedge clk); #1 pred_valid_i = 0;
        return;
      end
    end
    n_tests++; n_fail++;
    $display("FAIL pred_handshake_timeout: got no ready expected ready within 200 cycles");
    pred_valid_i = 0;
  endtask

  task automatic do_res(input logic br, input logic [3:0] prov, input logic upd, input logic [3:0] a0, a1, dec);
    br_result_i = br; res_valid_i = 1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (res_ready_o) begin
        res_q.push_back({prov, upd, lfsr_m[0] ? a1 : a0, dec});
        lfsr_m = {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
        @(posedge clk); #1 res_valid_i = 0;
        return;
      end
    end
    n_tests++; n_fail++;
    $display("FAIL res_handshake_timeout: got no ready expected ready within 200 cycles");
    res_valid_i = 0;
  endtask

  task automatic run_vec(input vec_t v);
    do_pred(v.hit, v.pr, v.ne, v.u, v.base, v.ep);
    do_res(v.br, v.prov, v.upd, v.a0, v.a1, v.dec);
  endtask

  task automatic flush_model();
    pred_q.delete(); res_q.delete(); lfsr_m = SEED;
  endtask

  initial begin
    //           hit      pred     ne      u      base ep  br  prov     upd a0       a1       dec
    vecs[0] = '{4'b0101, 4'b0100, 4'b0000, 8'h00, 0,  1,  1,  4'b0100, 1,  4'b0000, 4'b0000, 4'b0000};
    vecs[1] = '{4'b0010, 4'b0010, 4'b0000, 8'h00, 0,  1,  0,  4'b0010, 1,  4'b0100, 4'b1000, 4'b0000};
    vecs[2] = '{4'b0010, 4'b0010, 4'b0000, 8'h90, 0,  1,  0,  4'b0010, 1,  4'b0000, 4'b0000, 4'b1100};
    vecs[3] = '{4'b0000, 4'b1111, 4'b0000, 8'h11, 1,  1,  0,  4'b0000, 0,  4'b0010, 4'b1000, 4'b0000};
    vecs[4] = '{4'b1000, 4'b0000, 4'b0000, 8'hFF, 1,  0,  1,  4'b1000, 1,  4'b0000, 4'b0000, 4'b0000};
    vecs[5] = '{4'b1110, 4'b1010, 4'b0000, 8'h00, 0,  1,  1,  4'b1000, 1,  4'b0000, 4'b0000, 4'b0000};
    vecs[6] = '{4'b0011, 4'b0011, 4'b0000, 8'h4F, 0,  1,  0,  4'b0010, 0,  4'b0100, 4'b0100, 4'b0000};
    vecs[7] = '{4'b0000, 4'b0110, 4'b0000, 8'h00, 0,  0,  0,  4'b0000, 0,  4'b0000, 4'b0000, 4'b0000};
    vecs[8] = '{4'b0001, 4'b0000, 4'b0000, 8'h00, 1,  0,  1,  4'b0001, 1,  4'b0010, 4'b0100, 4'b0000};
    vecs[9] = '{4'b0001, 4'b0000, 4'b0000, 8'h54, 1,  0,  1,  4'b0001, 1,  4'b0000, 4'b0000, 4'b1110};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {pred_ready_o, pred_valid_o, pred_o, res_ready_o, provider_o, update_u_o,
                          alloc_o, dec_u_o, clr_valid_o, clr_idx_o, clr_col_o}, 0);
    @(posedge clk); #3 rst_n = 1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Resolve and reload the pending entry in the same cycle.
    do_pred(vecs[0].hit, vecs[0].pr, vecs[0].ne, vecs[0].u, vecs[0].base, vecs[0].ep);
    fork
      do_res(vecs[0].br, vecs[0].prov, vecs[0].upd, vecs[0].a0, vecs[0].a1, vecs[0].dec);
      do_pred(vecs[1].hit, vecs[1].pr, vecs[1].ne, vecs[1].u, vecs[1].base, vecs[1].ep);
    join
    do_res(vecs[1].br, vecs[1].prov, vecs[1].upd, vecs[1].a0, vecs[1].a1, vecs[1].dec);

`ifdef TAGE_USE_ALT_EN
    // Counter starts at 8: weak provider defers to alt; a wrong alt drops it to 7.
    do_pred(4'b0010, 4'b0010, 4'b0010, 8'h00, 0, 0);
    do_res(1, 4'b0010, 1, 4'b0100, 4'b1000, 4'b0000);
    do_pred(4'b0010, 4'b0010, 4'b0010, 8'h00, 0, 1);
    do_res(1, 4'b0010, 1, 4'b0000, 4'b0000, 4'b0000);
`endif

    // Async reset while the prediction strobe is up.
    do_pred(vecs[0].hit, vecs[0].pr, vecs[0].ne, vecs[0].u, vecs[0].base, vecs[0].ep);
    #1 chk("pred_valid_before_reset", pred_valid_o, 1);
    rst_n = 0;
    #1 chk("async_reset_outputs", {pred_ready_o, pred_valid_o, pred_o, res_ready_o, provider_o, update_u_o,
                                   alloc_o, dec_u_o, clr_valid_o, clr_idx_o, clr_col_o}, 0);
    flush_model();
    @(posedge clk); #3 rst_n = 1;
    run_vec(vecs[0]);
    run_vec(vecs[1]);

    // Reset in the middle of a column-1 sweep.
    begin : wait_col1
      for (int c = 0; c < 400; c++) begin
        @(negedge clk);
        if (m_sweep && m_col && m_idx >= 2 && m_idx <= 5) disable wait_col1;
      end
      n_tests++; n_fail++;
      $display("FAIL col1_sweep_timeout: got no column-1 sweep expected one within 400 cycles");
    end
    @(posedge clk);
    #1 chk("clr_col_before_reset", {clr_valid_o, clr_col_o}, 2'b11);
    #1 rst_n = 0;
    #1 chk("sweep_reset_clr", {clr_valid_o, clr_idx_o, clr_col_o}, 0);
    flush_model();
    @(posedge clk); #3 rst_n = 1;
    run_vec(vecs[3]);
    repeat (60) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
